// File: rtl/mode_ff_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : mode_ff_bank_if
// Brief    : Control/data bundle for the multi-mode flip-flop bank.
// Revision : 1.0  initial release
// ============================================================================
interface mode_ff_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             chg;
   logic             sr_err;
   logic [CNTW-1:0]  tog_cnt;

   modport master (
      output en, mode, a, b,
      input  q, qbar, chg, sr_err, tog_cnt
   );

   modport slave (
      input  en, mode, a, b,
      output q, qbar, chg, sr_err, tog_cnt
   );
endinterface
`default_nettype wire

// File: rtl/mode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : mode_ff_bank
// Brief    : WIDTH independent T/D/JK/SR flip-flops with change counter.
// Revision : 1.0  initial release
// ============================================================================
module mode_ff_bank #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   mode_ff_bank_if.slave bus
);
   localparam logic [1:0] C_MODE_T  = 2'b00;
   localparam logic [1:0] C_MODE_D  = 2'b01;
   localparam logic [1:0] C_MODE_JK = 2'b10;
   localparam logic [1:0] C_MODE_SR = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic             r_chg;
   logic             r_sr_err;
   logic [CNTW-1:0]  r_tog_cnt;

   logic [WIDTH-1:0] w_q_next;
   logic             w_changed;
   logic             w_sr_err;

   always_comb begin
      w_q_next = r_q;
      case (bus.mode)
         C_MODE_T:  w_q_next = r_q ^ bus.a;
         C_MODE_D:  w_q_next = bus.a;
         C_MODE_JK: w_q_next = (bus.a & ~r_q) | (~bus.b & r_q);
         // S=R=1 is treated as hold, so only the exclusive cases move the bit
         C_MODE_SR: w_q_next = (bus.a & ~bus.b) | (~bus.a & ~bus.b & r_q)
                             | (bus.a & bus.b & r_q);
         default:   w_q_next = r_q;
      endcase
   end

   assign w_changed = (w_q_next != r_q);
   assign w_sr_err  = (bus.mode == C_MODE_SR) && ((bus.a & bus.b) != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q       <= '0;
         r_chg     <= 1'b0;
         r_sr_err  <= 1'b0;
         r_tog_cnt <= '0;
      end else if (!bus.en) begin
         r_chg     <= 1'b0;
         r_sr_err  <= 1'b0;
      end else begin
         r_q       <= w_q_next;
         r_chg     <= w_changed;
         r_sr_err  <= w_sr_err;
         if (w_changed)
            r_tog_cnt <= r_tog_cnt + CNTW'(1);
      end
   end

   assign bus.q       = r_q;
   assign bus.qbar    = ~r_q;
   assign bus.chg     = r_chg;
   assign bus.sr_err  = r_sr_err;
   assign bus.tog_cnt = r_tog_cnt;
endmodule
`default_nettype wire

// File: tb/tb_mode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_ff_bank
// Brief    : Directed scoreboard bench; a 16-bit and a 2-bit counter instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_mode_ff_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mode_ff_bank_if #(.WIDTH(8), .CNTW(16)) if16 ();
   mode_ff_bank_if #(.WIDTH(8), .CNTW(2))  if2  ();

   mode_ff_bank #(.WIDTH(8), .CNTW(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
   mode_ff_bank #(.WIDTH(8), .CNTW(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.slave));

   typedef struct {
      logic [7:0]  q;
      logic        chg;
      logic        err;
      logic [15:0] cnt16;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  m_q     = 8'h00;
   logic [15:0] m_cnt16 = 16'h0;
   logic [1:0]  m_cnt2  = 2'h0;
   bit          m_valid = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive inputs while clk is high, confirm nothing moves before the edge,
   // then compare the registered results against the popped expectation.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic [1:0] md, input logic [7:0] a, input logic [7:0] b);
      exp_t       x;
      logic [7:0] nq;
      #1;
      rst = r;
      if16.en = e;  if16.mode = md;  if16.a = a;  if16.b = b;
      if2.en  = e;  if2.mode  = md;  if2.a  = a;  if2.b  = b;
      nq = m_q;
      for (int i = 0; i < 8; i++) begin
         case (md)
            2'b00: nq[i] = m_q[i] ^ a[i];
            2'b01: nq[i] = a[i];
            2'b10: case ({a[i], b[i]})
                      2'b00: nq[i] = m_q[i];
                      2'b01: nq[i] = 1'b0;
                      2'b10: nq[i] = 1'b1;
                      default: nq[i] = ~m_q[i];
                   endcase
            default: case ({a[i], b[i]})
                      2'b01: nq[i] = 1'b0;
                      2'b10: nq[i] = 1'b1;
                      default: nq[i] = m_q[i];
                   endcase
         endcase
      end
      if (!r) begin
         x = '{q: 8'h00, chg: 1'b0, err: 1'b0, cnt16: 16'h0, cnt2: 2'h0};
      end else if (!e) begin
         x = '{q: m_q, chg: 1'b0, err: 1'b0, cnt16: m_cnt16, cnt2: m_cnt2};
      end else begin
         x.q     = nq;
         x.chg   = (nq != m_q);
         x.err   = (md == 2'b11) && ((a & b) != 8'h00);
         x.cnt16 = m_cnt16 + ((nq != m_q) ? 16'd1 : 16'd0);
         x.cnt2  = m_cnt2 + ((nq != m_q) ? 2'd1 : 2'd0);
      end
      sb.push_back(x);
      @(negedge clk);
      if (m_valid) chk({tag, "_stable"}, {24'h0, if16.q}, {24'h0, m_q});
      @(posedge clk);
      #1;
      x = sb.pop_front();
      m_q = x.q;  m_cnt16 = x.cnt16;  m_cnt2 = x.cnt2;  m_valid = 1'b1;
      chk({tag, "_q"},      {24'h0, if16.q},      {24'h0, x.q});
      chk({tag, "_qbar"},   {24'h0, if16.qbar},   {24'h0, ~x.q});
      chk({tag, "_chg"},    {31'h0, if16.chg},    {31'h0, x.chg});
      chk({tag, "_sr_err"}, {31'h0, if16.sr_err}, {31'h0, x.err});
      chk({tag, "_cnt16"},  {16'h0, if16.tog_cnt}, {16'h0, x.cnt16});
      chk({tag, "_q2"},     {24'h0, if2.q},       {24'h0, x.q});
      chk({tag, "_cnt2"},   {30'h0, if2.tog_cnt}, {30'h0, x.cnt2});
   endtask

   initial begin
      if16.en = 1'b0;  if16.mode = 2'b00;  if16.a = 8'h00;  if16.b = 8'h00;
      if2.en  = 1'b0;  if2.mode  = 2'b00;  if2.a  = 8'h00;  if2.b  = 8'h00;
      @(posedge clk);

      step("rst0", 1'b0, 1'b1, 2'b00, 8'hFF, 8'h00);
      chk("rst0_qbar_ones", {24'h0, if16.qbar}, 32'h0000_00FF);

      step("t1", 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00);
      chk("t1_const", {24'h0, if16.q}, 32'h0000_00FF);
      step("t2", 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00);
      chk("t2_const", {24'h0, if16.q}, 32'h0000_0000);
      step("t3", 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00);
      chk("t3_cnt_const", {16'h0, if16.tog_cnt}, 32'd3);

      step("d_a5", 1'b1, 1'b1, 2'b01, 8'hA5, 8'h00);
      chk("d_a5_qbar_const", {24'h0, if16.qbar}, 32'h0000_005A);
      step("d_rep", 1'b1, 1'b1, 2'b01, 8'hA5, 8'h00);
      chk("d_rep_chg_const", {31'h0, if16.chg}, 32'd0);

      // q=0F, J=33, K=55: hold/clear/set/toggle per bit gives 3A
      step("d_0f", 1'b1, 1'b1, 2'b01, 8'h0F, 8'hFF);
      step("jk", 1'b1, 1'b1, 2'b10, 8'h33, 8'h55);
      chk("jk_const", {24'h0, if16.q}, 32'h0000_003A);

      step("d_00", 1'b1, 1'b1, 2'b01, 8'h00, 8'h00);
      step("sr1", 1'b1, 1'b1, 2'b11, 8'h81, 8'h01);
      chk("sr1_const", {24'h0, if16.q}, 32'h0000_0080);
      chk("sr1_err_const", {31'h0, if16.sr_err}, 32'd1);
      step("sr_hold", 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
      step("sr_ff", 1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF);
      step("en0_clr", 1'b1, 1'b0, 2'b11, 8'hFF, 8'hFF);

      step("rst_w", 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      step("w1", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00);
      step("w2", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00);
      step("w3", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00);
      step("w4", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00);
      chk("wrap_const", {30'h0, if2.tog_cnt}, 32'd0);
      step("en0_hold", 1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);

      step("d_aa", 1'b1, 1'b1, 2'b01, 8'hAA, 8'h00);
      step("jk_mix", 1'b1, 1'b1, 2'b10, 8'hF0, 8'h3C);
      step("d_aa2", 1'b1, 1'b1, 2'b01, 8'hAA, 8'h00);
      step("rst_win", 1'b0, 1'b1, 2'b00, 8'hFF, 8'h00);
      chk("rst_win_cnt_const", {16'h0, if16.tog_cnt}, 32'd0);
      step("post_rst", 1'b1, 1'b1, 2'b00, 8'h3C, 8'h00);
      chk("post_rst_const", {24'h0, if16.q}, 32'h0000_003C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
